// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared I2C definitions: field widths and the target engine's state encoding.
package i2c_slave_byte_ctrl_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_slv_state_e;

endpackage

// File: rtl/i2c_slave_byte_ctrl_if.sv
// Bus pins plus byte handshake between the I2C target and local register logic.
interface i2c_slave_byte_ctrl_if;
  import i2c_slave_byte_ctrl_pkg::*;

  logic                  ena;
  logic                  scl_i;
  logic                  scl_o;
  logic                  scl_oen;
  logic                  sda_i;
  logic                  sda_o;
  logic                  sda_oen;
  logic                  busy;
  logic                  selected;
  logic                  rw;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_req;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  nack_rcvd;

  modport slave (
    input  ena, scl_i, sda_i, tx_data, tx_valid,
    output scl_o, scl_oen, sda_o, sda_oen, busy, selected, rw,
           rx_data, rx_valid, tx_req, nack_rcvd
  );

  modport master (
    output ena, scl_i, sda_i, tx_data, tx_valid,
    input  scl_o, scl_oen, sda_o, sda_oen, busy, selected, rw,
           rx_data, rx_valid, tx_req, nack_rcvd
  );

endinterface

// File: rtl/i2c_slave_byte_ctrl_bus_monitor.sv
// I2C line conditioner: synchronises SCL/SDA and emits registered rise/fall,
// START/STOP events and bus-busy. Shared by master and target engines.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_bit,
  output logic rise,
  output logic fall,
  output logic start,
  output logic stop,
  output logic busy
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_dly_q, scl_dly_d;
  logic       sda_dly_q, sda_dly_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       sda_bit_q, sda_bit_d;
  logic       sscl, ssda;

  assign sscl = scl_sync_q[1];
  assign ssda = sda_sync_q[1];

  // Edge/condition detection; sda_bit is the SDA level that goes with the event
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_dly_d  = sscl;
    sda_dly_d  = ssda;
    rise_d     = sscl & ~scl_dly_q;
    fall_d     = ~sscl & scl_dly_q;
    start_d    = sscl & sda_dly_q & ~ssda;
    stop_d     = sscl & ~sda_dly_q & ssda;
    sda_bit_d  = ssda;
    busy_d     = busy_q;
    if (start_d) begin
      busy_d = 1'b1;
    end else if (stop_d) begin
      busy_d = 1'b0;
    end
  end

  // Synchroniser chain and event registers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      sda_bit_q  <= sda_bit_d;
    end
  end

  assign sda_bit = sda_bit_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign start   = start_q;
  assign stop    = stop_q;
  assign busy    = busy_q;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte engine: address match, ACK generation, byte shift in/out
// and a byte handshake to local logic. Open-drain outputs (constant 0 + OEN).
// Optional clock stretching while waiting for read data: I2C_SLAVE_STRETCH_EN.
module i2c_slave_byte_ctrl
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_slave_byte_ctrl_if.slave bus
);

  logic rise, fall, start, stop, busy, sda_bit;

  i2c_bus_monitor u_mon (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (bus.scl_i),
    .sda_i   (bus.sda_i),
    .sda_bit (sda_bit),
    .rise    (rise),
    .fall    (fall),
    .start   (start),
    .stop    (stop),
    .busy    (busy)
  );

  i2c_slv_state_e        state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [I2C_BYTE_W-1:0] sr_q, sr_d;
  logic [I2C_BYTE_W-1:0] txsr_q, txsr_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  sda_oen_q, sda_oen_d;
  logic                  selected_q, selected_d;
  logic                  rw_q, rw_d;
  logic                  pend_q, pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  nack_q, nack_d;
  logic                  load_req;
  logic                  stretching;

`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_oen_q, scl_oen_d;
  logic stretch_q, stretch_d;
  logic rel_q, rel_d;
  assign stretching = stretch_q;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = bus.tx_valid;
  assign stretching      = 1'b0;
`endif

  // Next-state logic; pend marks "byte/ack decided, act on the coming SCL fall"
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    txsr_d     = txsr_q;
    rx_data_d  = rx_data_q;
    sda_oen_d  = sda_oen_q;
    selected_d = selected_q;
    rw_d       = rw_q;
    pend_d     = pend_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    load_req   = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
    scl_oen_d  = scl_oen_q;
    stretch_d  = stretch_q;
    rel_d      = 1'b0;
`endif

    if (!bus.ena || stop) begin
      state_d    = IDLE;
      sda_oen_d  = 1'b1;
      selected_d = 1'b0;
      pend_d     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oen_d  = 1'b1;
      stretch_d  = 1'b0;
`endif
    end else if (start) begin
      state_d    = ADDR;
      bitcnt_d   = 3'd0;
      sda_oen_d  = 1'b1;
      selected_d = 1'b0;
      pend_d     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oen_d  = 1'b1;
      stretch_d  = 1'b0;
`endif
    end else if (stretching) begin
      load_req = 1'b1;
    end else begin
      case (state_q)
        ADDR, WR_BYTE: begin
          if (rise) begin
            sr_d     = {sr_q[6:0], sda_bit};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (state_q == WR_BYTE) begin
                rx_data_d  = {sr_q[6:0], sda_bit};
                rx_valid_d = 1'b1;
                pend_d     = 1'b1;
              end else if (sr_q[6:0] == SLAVE_ADDR) begin
                rw_d       = sda_bit;
                selected_d = 1'b1;
                pend_d     = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end else if (fall && pend_q) begin
            pend_d    = 1'b0;
            sda_oen_d = 1'b0;
            state_d   = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
          end
        end
        ADDR_ACK: begin
          if (rise && rw_q) begin
            tx_req_d = 1'b1;
          end else if (fall) begin
            if (rw_q) begin
              load_req = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              bitcnt_d  = 3'd0;
              state_d   = WR_BYTE;
            end
          end
        end
        WR_ACK: begin
          if (fall) begin
            sda_oen_d = 1'b1;
            bitcnt_d  = 3'd0;
            state_d   = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (fall) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              sda_oen_d = 1'b1;
              state_d   = RD_ACK;
            end else begin
              sda_oen_d = txsr_q[7];
              txsr_d    = {txsr_q[6:0], 1'b1};
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            if (!sda_bit) begin
              tx_req_d = 1'b1;
              pend_d   = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end
          end else if (fall && pend_q) begin
            pend_d   = 1'b0;
            load_req = 1'b1;
          end
        end
        IGNORE: begin
          sda_oen_d = 1'b1;
        end
        default: begin
        end
      endcase
    end

    // Read-data load point: drive bit 7 now, remaining bits shift out on falls
    if (load_req) begin
`ifdef I2C_SLAVE_STRETCH_EN
      if (bus.tx_valid) begin
        txsr_d    = {bus.tx_data[6:0], 1'b1};
        sda_oen_d = bus.tx_data[7];
        bitcnt_d  = 3'd0;
        state_d   = RD_BYTE;
        stretch_d = 1'b0;
        rel_d     = stretch_q;
      end else begin
        scl_oen_d = 1'b0;
        stretch_d = 1'b1;
      end
`else
      txsr_d    = {bus.tx_data[6:0], 1'b1};
      sda_oen_d = bus.tx_data[7];
      bitcnt_d  = 3'd0;
      state_d   = RD_BYTE;
`endif
    end
`ifdef I2C_SLAVE_STRETCH_EN
    // SCL is let go one clk after the stretched byte was loaded
    if (rel_q) begin
      scl_oen_d = 1'b1;
    end
`endif
  end

  // State and output registers; shift registers carry no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      rx_data_q  <= '0;
      sda_oen_q  <= 1'b1;
      selected_q <= 1'b0;
      rw_q       <= 1'b0;
      pend_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oen_q  <= 1'b1;
      stretch_q  <= 1'b0;
      rel_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_data_q  <= rx_data_d;
      sda_oen_q  <= sda_oen_d;
      selected_q <= selected_d;
      rw_q       <= rw_d;
      pend_q     <= pend_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      nack_q     <= nack_d;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oen_q  <= scl_oen_d;
      stretch_q  <= stretch_d;
      rel_q      <= rel_d;
`endif
    end
    sr_q   <= sr_d;
    txsr_q <= txsr_d;
  end

  assign bus.scl_o     = 1'b0;
  assign bus.sda_o     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
  assign bus.scl_oen   = scl_oen_q;
`else
  assign bus.scl_oen   = 1'b1;
`endif
  assign bus.sda_oen   = sda_oen_q;
  assign bus.busy      = busy;
  assign bus.selected  = selected_q;
  assign bus.rw        = rw_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.nack_rcvd = nack_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for the I2C target: a bit-level bus master, an I2C transaction model
// that predicts handshake events into a scoreboard, and a monitor that checks them.
module tb_i2c_slave_byte_ctrl;
  import i2c_slave_byte_ctrl_pkg::*;

  localparam logic [6:0] SADDR = 7'h50;
  localparam int Q = 6;
  localparam int EV_RX = 0;
  localparam int EV_TXREQ = 1;
  localparam int EV_NACK = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid_r = 1'b1;
  int         total = 0;
  int         bad = 0;
  ev_t        sb[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  i2c_slave_byte_ctrl_if bus();

  // Open-drain wired-AND of master and target
  assign bus.scl_i    = m_scl & (bus.scl_oen | bus.scl_o);
  assign bus.sda_i    = m_sda & (bus.sda_oen | bus.sda_o);
  assign bus.tx_data  = tx_byte;
  assign bus.tx_valid = tx_valid_r;

  i2c_slave_byte_ctrl #(.SLAVE_ADDR(SADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == EV_RX) chk("rx_data", d, e.data);
    end
  endtask

  // Monitor: pops the scoreboard whenever the target presents a pulse
  always @(negedge clk) begin
    if (bus.rx_valid) expect_ev(EV_RX, bus.rx_data);
    if (bus.tx_req) begin
      expect_ev(EV_TXREQ, 8'h00);
      if (txq.size() > 0) tx_byte = txq.pop_front();
    end
    if (bus.nack_rcvd) expect_ev(EV_NACK, 8'h00);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int k;
    k = 0;
    m_scl = 1'b1;
    while (!bus.scl_i && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.scl_i) begin
      total++;
      bad++;
      $display("FAIL scl_release: got 0 expected 1");
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_n(Q);
    m_sda = b;
    wait_n(Q);
    scl_high();
    wait_n(Q);
    s = bus.sda_i;
    wait_n(Q);
    m_scl = 1'b0;
  endtask

  task automatic start_c();
    if (!m_scl) begin
      wait_n(Q);
      m_sda = 1'b1;
      wait_n(Q);
      scl_high();
      wait_n(Q);
    end else begin
      wait_n(2 * Q);
    end
    m_sda = 1'b0;
    wait_n(2 * Q);
    m_scl = 1'b0;
  endtask

  task automatic stop_c();
    wait_n(Q);
    m_sda = 1'b0;
    wait_n(Q);
    scl_high();
    wait_n(2 * Q);
    m_sda = 1'b1;
    wait_n(4 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(mack, s);
  endtask

  // One bus transaction; the model predicts ACKs, read bits and events from I2C rules
  task automatic txn(input logic [6:0] addr, input logic rd, input int n,
                     input logic [3:0][7:0] d, input logic do_stop);
    logic       hit;
    logic       ack;
    logic [7:0] got;
    hit = (addr == SADDR) && bus.ena;
    if (hit) begin
      if (rd) begin
        sb.push_back(ev_t'{EV_TXREQ, 8'h00});
        for (int i = 0; i < n; i++) begin
          txq.push_back(d[i]);
          if (i < n - 1) sb.push_back(ev_t'{EV_TXREQ, 8'h00});
          else           sb.push_back(ev_t'{EV_NACK, 8'h00});
        end
      end else begin
        for (int i = 0; i < n; i++) sb.push_back(ev_t'{EV_RX, d[i]});
      end
    end
    start_c();
    send_byte({addr, rd}, ack);
    chk("addr_ack", ack, !hit);
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        recv_byte(i == n - 1, got);
        chk("read_bits", got, hit ? d[i] : 8'hFF);
      end else begin
        send_byte(d[i], ack);
        chk("write_ack", ack, !hit);
      end
    end
    chk("busy_in_txn", bus.busy, 1'b1);
    chk("selected_in_txn", bus.selected, hit);
    if (hit) chk("rw", bus.rw, rd);
    if (hit && !rd) chk("rx_data_last", bus.rx_data, d[n - 1]);
    if (do_stop) begin
      stop_c();
      chk("busy_after_stop", bus.busy, 1'b0);
      chk("selected_after_stop", bus.selected, 1'b0);
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_sda_oen"}, bus.sda_oen, 1'b1);
    chk({tag, "_scl_oen"}, bus.scl_oen, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_selected"}, bus.selected, 1'b0);
    chk({tag, "_rw"}, bus.rw, 1'b0);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_pulses"}, {bus.rx_valid, bus.tx_req, bus.nack_rcvd}, 3'b000);
  endtask

`ifdef I2C_SLAVE_STRETCH_EN
  logic       stretch_arm = 1'b0;
  logic       stretch_done = 1'b0;
  logic [7:0] stretch_exp = 8'h00;

  // Withholds tx_valid at the first read load point and checks the SCL hold
  always begin
    @(negedge clk);
    if (stretch_arm && !stretch_done && bus.tx_req) begin
      int k;
      tx_valid_r = 1'b0;
      k = 0;
      while (bus.scl_oen && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("stretch_begin", bus.scl_oen, 1'b0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("stretch_hold", bus.scl_oen, 1'b0);
      end
      tx_valid_r = 1'b1;
      @(negedge clk);
      chk("stretch_bit7", bus.sda_oen, stretch_exp[7]);
      chk("stretch_hold_at_load", bus.scl_oen, 1'b0);
      @(negedge clk);
      chk("stretch_release", bus.scl_oen, 1'b1);
      stretch_done = 1'b1;
    end
  end
`endif

  initial begin
    logic       s;
    logic       ack;
    logic [6:0] a;
    logic       rd;
    int         n;
    logic [3:0][7:0] d;

    bus.ena = 1'b1;
    rst = 1'b1;
    wait_n(4);
    reset_outputs("reset");
    rst = 1'b0;
    wait_n(4);

    // Write two bytes to our address
    txn(SADDR, 1'b0, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 1'b1);
    // Foreign address is ignored
    txn(7'h51, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h12}, 1'b1);
    // Read two bytes, ACK then NACK
    txn(SADDR, 1'b1, 2, {8'h00, 8'h00, 8'h0F, 8'h96}, 1'b1);
    // Write then repeated START into a read
    txn(SADDR, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
    txn(SADDR, 1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b1);
    chk("rx_data_after_rs", bus.rx_data, 8'h01);

    // Reset while the target drives the data ACK low
    sb.push_back(ev_t'{EV_RX, 8'hC3});
    start_c();
    send_byte({SADDR, 1'b0}, ack);
    chk("rst_case_addr_ack", ack, 1'b0);
    for (int i = 7; i >= 0; i--) clk_bit(d[0][0] | 1'b1 ? (8'hC3 >> i) & 1 : 1'b0, s);
    n = 0;
    while (bus.sda_oen && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ack_driven", bus.sda_oen, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_outputs("midrst");
    clk_bit(1'b1, s);
    chk("ack_after_rst", s, 1'b1);
    stop_c();

    // Disabled core does not respond
    bus.ena = 1'b0;
    txn(SADDR, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h77}, 1'b1);
    bus.ena = 1'b1;
    wait_n(4);

    // Randomised transactions
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        do a = 7'($urandom_range(0, 127)); while (a == SADDR);
      end else begin
        a = SADDR;
      end
      rd = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      d  = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      txn(a, rd, n, d, 1'b1);
    end

`ifdef I2C_SLAVE_STRETCH_EN
    stretch_exp = 8'h3C;
    stretch_arm = 1'b1;
    txn(SADDR, 1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h3C}, 1'b1);
    stretch_arm = 1'b0;
    chk("stretch_seen", stretch_done, 1'b1);
`endif

    wait_n(10);
    chk("scoreboard_drained", sb.size(), 0);
    chk("txq_drained", txq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_slave_byte_ctrl.md
Name: i2c_slave_byte_ctrl

Overview:
- I2C target (slave) engine: the responding end of the bus that the team's I2C master bit controller drives.
- Monitors SCL/SDA and matches a 7-bit address.
- ACKs the address and received bytes; shifts bytes in (master write) or out (master read).
- Presents a byte-wide handshake to local register logic.
- Open-drain style: constant-0 outputs plus active-low output enables for the pad cells.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  core enable; 0 forces IDLE with lines released
- scl_i  in  1  SCL pad input
- scl_o  out  1  SCL output, constant 0
- scl_oen  out  1  SCL output enable, active-low; held 1 unless stretching
- sda_i  in  1  SDA pad input
- sda_o  out  1  SDA output, constant 0
- sda_oen  out  1  SDA output enable, active-low
- busy  out  1  bus busy, START seen and no STOP yet
- selected  out  1  addressed: address match through STOP or repeated START
- rw  out  1  R/W bit latched at address match (1 = master reads)
- rx_data  out  8  last byte written by master
- rx_valid  out  1  1-clk pulse, rx_data updated
- tx_req  out  1  1-clk pulse, next read byte needed
- tx_data  in  8  byte to send to master
- tx_valid  in  1  tx_data available (used only with stretch feature)
- nack_rcvd  out  1  1-clk pulse, master NACKed a read byte

Behaviour:
- Reset (rst=1 at clk edge):
  - State IDLE; scl_oen = sda_oen = 1.
  - busy, selected, rw, rx_valid, tx_req, nack_rcvd = 0; rx_data = 8'h00.
  - Synchronisers and delayed copies = 1.
  - rst mid-transfer releases SDA on the next clk.
- Input conditioning:
  - Two-flop sync gives sSCL/sSDA; one more flop gives dSCL/dSDA.
  - rise = sSCL & ~dSCL; fall = ~sSCL & dSCL.
  - START = sSCL & dSDA & ~sSDA; STOP = sSCL & ~dSDA & sSDA.
  - Events are registered: pin-to-event latency is 3 clk.
- busy: set on START, cleared on STOP, regardless of selected.
- STOP in any state: go to IDLE, sda_oen = 1, selected = 0.
- START in any state (including repeated START): go to ADDR, bit counter = 0, selected = 0.
- ena = 0: behaves as IDLE, no pulses, lines released; busy tracking continues.
- States and transitions:
  - IDLE: START -> ADDR.
  - ADDR: sSDA shifted MSB-first on each rise. At the 8th rise, compare sr[7:1] with SLAVE_ADDR.
    - Match: rw <= sr[0], selected <= 1; at the next fall, sda_oen <= 0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE.
    - Address 7'h00 matches only when SLAVE_ADDR = 0.
  - ADDR_ACK: if rw = 1, tx_req pulses on the ACK-clock rise. At the ACK-clock fall:
    - rw = 0: sda_oen <= 1, go to WR_BYTE.
    - rw = 1: load tx shift register from tx_data, sda_oen <= tx_data[7], go to RD_BYTE.
  - WR_BYTE: shift on each rise. At the 8th rise: rx_data <= shift register and rx_valid pulses in the same cycle. At the next fall: sda_oen <= 0, go to WR_ACK. Every written byte is ACKed.
  - WR_ACK: at the fall, sda_oen <= 1, go to WR_BYTE.
  - RD_BYTE: at each fall, drive the next bit (sda_oen = bit value). At the fall ending bit 0: sda_oen <= 1, go to RD_ACK.
  - RD_ACK: sample sSDA at the rise.
    - 0 (ACK): tx_req pulses; at the next fall, load tx_data, drive bit 7, go to RD_BYTE.
    - 1 (NACK): nack_rcvd pulses; go to IGNORE.
  - IGNORE: lines released; leave only on START or STOP.
- Bit counter: 3-bit, wraps 7 -> 0 per byte.
- SDA changes only on a fall, so the target's own drive never forms a false START/STOP.
- Without the stretch feature, tx_data must be valid from the tx_req cycle until the next SCL fall (half an SCL period); tx_valid is ignored.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined: at the fall where tx_data would be loaded, tx_valid = 0 makes scl_oen <= 0 (SCL held low) in that cycle. The target waits in place.
  - The first clk with tx_valid = 1: load tx_data, drive bit 7 on SDA.
  - One clk later: scl_oen <= 1.
  - STOP/START/rst during the stretch releases SCL immediately.
- Undefined: scl_oen is constant 1; tx_valid is unused.

Decomposition:
- Shared defines file (alongside the I2C command defines):
  - state encodings: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE;
  - I2C_ADDR_W = 7; I2C_BYTE_W = 8.
- Sub-module i2c_bus_monitor: synchronisers plus rise/fall/START/STOP/busy detection. The master side can reuse it.

Test Plan:
- Master writes addr 0x50 W, then 0xA5, 0x3C, then STOP:
  - ACK low on all three 9th clocks;
  - rx_valid pulses twice with rx_data 0xA5 then 0x3C;
  - busy falls after STOP; selected = 0.
- Master sends addr 0x51:
  - no ACK (SDA stays high); state IGNORE; no pulses;
  - busy high until STOP.
- Master reads addr 0x50 R with tx_data 0x96 then 0x0F, ACK then NACK:
  - SDA bit stream 1001_0110, 0000_1111;
  - tx_req pulses twice; nack_rcvd pulses once; then IGNORE.
- Write 0x50 W, byte 0x01, repeated START, 0x50 R:
  - rx_data = 0x01; rw becomes 1; tx_req pulses.
- rst asserted while the target drives SDA low in WR_ACK:
  - sda_oen = 1 on the next clk; all outputs at reset values.
- STRETCH_EN, tx_valid held low for 20 clk at the read load point:
  - scl_oen = 0 for those cycles;
  - bit 7 drives on the first tx_valid cycle; SCL released one clk later.
